// File: rtl/spmm_row_engine.sv
// Streaming CSR-row x dense-W engine: accumulates one sparse row against
// a local weight store and emits one scaled dense result row per CSR row.
module spmm_row_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int H_NUM_OF_COLS = 16,
    parameter int W_NUM_OF_COLS = 16,
    parameter int FRAC_BITS     = 0,
    parameter int SATURATE      = 1,
    parameter int ROW_IDX_WIDTH = 10,
    parameter int COL_IDX_WIDTH = $clog2(H_NUM_OF_COLS),
    parameter int ACC_WIDTH     = 2*DATA_WIDTH+$clog2(H_NUM_OF_COLS)+1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              w_we_i,
    input  logic [COL_IDX_WIDTH-1:0]          w_addr_i,
    input  logic [W_NUM_OF_COLS*DATA_WIDTH-1:0] w_row_i,
    input  logic                              nz_valid_i,
    output logic                              nz_ready_o,
    input  logic [COL_IDX_WIDTH-1:0]          nz_col_idx_i,
    input  logic [DATA_WIDTH-1:0]             nz_value_i,
    input  logic                              nz_last_i,
    input  logic                              nz_empty_i,
    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic [W_NUM_OF_COLS*DATA_WIDTH-1:0] res_data_o,
    output logic [ROW_IDX_WIDTH-1:0]          res_row_idx_o,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int RW = W_NUM_OF_COLS*DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'(2**(DATA_WIDTH-1)-1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [COL_IDX_WIDTH:0] H_LIM =
        (COL_IDX_WIDTH+1)'(H_NUM_OF_COLS);

    logic [RW-1:0] w_q [H_NUM_OF_COLS];
    logic [RW-1:0] w_d [H_NUM_OF_COLS];
    logic signed [ACC_WIDTH-1:0] acc_q [W_NUM_OF_COLS];
    logic signed [ACC_WIDTH-1:0] acc_d [W_NUM_OF_COLS];
    logic signed [ACC_WIDTH-1:0] prod [W_NUM_OF_COLS];
    logic signed [ACC_WIDTH-1:0] sum [W_NUM_OF_COLS];
    logic signed [ACC_WIDTH-1:0] shf [W_NUM_OF_COLS];

    logic busy_q, busy_d;
    logic res_valid_q, res_valid_d;
    logic err_q, err_d;
    logic [RW-1:0] res_data_q, res_data_d;
    logic [ROW_IDX_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [ROW_IDX_WIDTH-1:0] res_row_idx_q, res_row_idx_d;

    logic accept;
    logic in_range;
    logic w_in_range;
    logic [RW-1:0] rd_row;
    logic [DATA_WIDTH-1:0] el;

    assign nz_ready_o    = !res_valid_q || res_ready_i;
    assign accept        = nz_valid_i && nz_ready_o;
    assign in_range      = {1'b0, nz_col_idx_i} < H_LIM;
    assign w_in_range    = {1'b0, w_addr_i} < H_LIM;
    assign rd_row        = in_range ? w_q[nz_col_idx_i] : '0;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_row_idx_o = res_row_idx_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;

    always_comb begin
        w_d           = w_q;
        acc_d         = acc_q;
        busy_d        = busy_q;
        res_valid_d   = res_valid_q;
        err_d         = err_q;
        res_data_d    = res_data_q;
        row_cnt_d     = row_cnt_q;
        res_row_idx_d = res_row_idx_q;
        el            = '0;

        if (w_we_i && w_in_range) begin
            w_d[w_addr_i] = w_row_i;
        end

        for (int j = 0; j < W_NUM_OF_COLS; j++) begin
            prod[j] = '0;
            if (in_range && !nz_empty_i) begin
                prod[j] = ACC_WIDTH'($signed(nz_value_i)) *
                    ACC_WIDTH'($signed(rd_row[j*DATA_WIDTH +: DATA_WIDTH]));
            end
            sum[j] = acc_q[j] + prod[j];
            shf[j] = sum[j] >>> FRAC_BITS;
        end

        if (res_valid_q && res_ready_i) begin
            res_valid_d = 1'b0;
        end

        if (accept) begin
            acc_d  = sum;
            busy_d = 1'b1;
            // Empty beats ignore the index, so they never flag an error.
            if (!in_range && !nz_empty_i) begin
                err_d = 1'b1;
            end
            if (nz_last_i) begin
                for (int j = 0; j < W_NUM_OF_COLS; j++) begin
                    el = shf[j][DATA_WIDTH-1:0];
                    if (SATURATE != 0) begin
                        if (shf[j] > SAT_MAX) el = SAT_MAX[DATA_WIDTH-1:0];
                        if (shf[j] < SAT_MIN) el = SAT_MIN[DATA_WIDTH-1:0];
                    end
                    res_data_d[j*DATA_WIDTH +: DATA_WIDTH] = el;
                    acc_d[j] = '0;
                end
                busy_d        = 1'b0;
                res_valid_d   = 1'b1;
                res_row_idx_d = row_cnt_q;
                row_cnt_d     = row_cnt_q + ROW_IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < H_NUM_OF_COLS; i++) w_q[i] <= '0;
            for (int j = 0; j < W_NUM_OF_COLS; j++) acc_q[j] <= '0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            res_data_q    <= '0;
            row_cnt_q     <= '0;
            res_row_idx_q <= '0;
        end else begin
            w_q           <= w_d;
            acc_q         <= acc_d;
            busy_q        <= busy_d;
            res_valid_q   <= res_valid_d;
            err_q         <= err_d;
            res_data_q    <= res_data_d;
            row_cnt_q     <= row_cnt_d;
            res_row_idx_q <= res_row_idx_d;
        end
    end

endmodule

// File: tb/tb_spmm_row_engine.sv
// Bench: three engine variants (sat, wrap, frac=2) driven in lockstep,
// checked by a reference-model scoreboard plus hand-written corner cases.
module tb_spmm_row_engine;

    localparam int DW = 8;
    localparam int HN = 5;
    localparam int WN = 4;

    logic clk, rst_n;
    logic w_we;
    logic [2:0] w_addr;
    logic [31:0] w_row;
    logic nz_valid, nz_last, nz_empty;
    logic [2:0] nz_col;
    logic [7:0] nz_val;
    logic res_ready;

    logic [31:0] rd [3];
    logic [9:0] ri [3];
    logic rv [3], rdy [3], bsy [3], er [3];

    typedef struct packed {
        logic [9:0] i;
        logic [2:0][31:0] d;
    } exp_t;

    typedef struct {
        int col;
        int val;
        bit last;
        bit empty;
        bit exp_busy;
    } vec_t;

    exp_t sbq[$];
    int wm [HN][WN];
    int accm [WN];
    int rowm;
    int ncmp, nerr;

    spmm_row_engine #(.DATA_WIDTH(DW), .H_NUM_OF_COLS(HN),
        .W_NUM_OF_COLS(WN), .FRAC_BITS(0), .SATURATE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .w_we_i(w_we), .w_addr_i(w_addr),
        .w_row_i(w_row), .nz_valid_i(nz_valid), .nz_ready_o(rdy[0]),
        .nz_col_idx_i(nz_col), .nz_value_i(nz_val), .nz_last_i(nz_last),
        .nz_empty_i(nz_empty), .res_valid_o(rv[0]), .res_ready_i(res_ready),
        .res_data_o(rd[0]), .res_row_idx_o(ri[0]), .busy_o(bsy[0]),
        .err_o(er[0]));

    spmm_row_engine #(.DATA_WIDTH(DW), .H_NUM_OF_COLS(HN),
        .W_NUM_OF_COLS(WN), .FRAC_BITS(0), .SATURATE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .w_we_i(w_we), .w_addr_i(w_addr),
        .w_row_i(w_row), .nz_valid_i(nz_valid), .nz_ready_o(rdy[1]),
        .nz_col_idx_i(nz_col), .nz_value_i(nz_val), .nz_last_i(nz_last),
        .nz_empty_i(nz_empty), .res_valid_o(rv[1]), .res_ready_i(res_ready),
        .res_data_o(rd[1]), .res_row_idx_o(ri[1]), .busy_o(bsy[1]),
        .err_o(er[1]));

    spmm_row_engine #(.DATA_WIDTH(DW), .H_NUM_OF_COLS(HN),
        .W_NUM_OF_COLS(WN), .FRAC_BITS(2), .SATURATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .w_we_i(w_we), .w_addr_i(w_addr),
        .w_row_i(w_row), .nz_valid_i(nz_valid), .nz_ready_o(rdy[2]),
        .nz_col_idx_i(nz_col), .nz_value_i(nz_val), .nz_last_i(nz_last),
        .nz_empty_i(nz_empty), .res_valid_o(rv[2]), .res_ready_i(res_ready),
        .res_data_o(rd[2]), .res_row_idx_o(ri[2]), .busy_o(bsy[2]),
        .err_o(er[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] fin(int s, int frac, bit sat);
        int t;
        t = s >>> frac;
        if (sat) begin
            if (t > 127) t = 127;
            if (t < -128) t = -128;
        end
        return t[7:0];
    endfunction

    task automatic model_beat(int col, int val, bit last, bit empty);
        exp_t e;
        for (int j = 0; j < WN; j++) begin
            if (!empty && col < HN) accm[j] += val * wm[col][j];
        end
        if (last) begin
            e.i = rowm[9:0];
            for (int j = 0; j < WN; j++) begin
                e.d[0][j*8 +: 8] = fin(accm[j], 0, 1);
                e.d[1][j*8 +: 8] = fin(accm[j], 0, 0);
                e.d[2][j*8 +: 8] = fin(accm[j], 2, 1);
                accm[j] = 0;
            end
            sbq.push_back(e);
            rowm++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HN; i++)
            for (int j = 0; j < WN; j++) wm[i][j] = 0;
        for (int j = 0; j < WN; j++) accm[j] = 0;
        rowm = 0;
        sbq.delete();
    endtask

    task automatic load_w(int a, logic [31:0] r);
        w_we = 1'b1;
        w_addr = a[2:0];
        w_row = r;
        @(posedge clk);
        #1 w_we = 1'b0;
        for (int j = 0; j < WN; j++) begin
            logic [7:0] b;
            b = r[j*8 +: 8];
            wm[a][j] = int'($signed(b));
        end
    endtask

    task automatic load_identity();
        for (int i = 0; i < HN; i++) begin
            logic [31:0] r;
            r = '0;
            if (i < WN) r[i*8 +: 8] = 8'd1;
            load_w(i, r);
        end
    endtask

    task automatic send_beat(int col, int val, bit last, bit empty);
        int n;
        nz_valid = 1'b1;
        nz_col = col[2:0];
        nz_val = val[7:0];
        nz_last = last;
        nz_empty = empty;
        n = 0;
        @(negedge clk);
        while (!rdy[0] && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!rdy[0]) begin
            ncmp++;
            nerr++;
            $display("FAIL beat_timeout: got ready=0 want ready=1");
            nz_valid = 1'b0;
            return;
        end
        model_beat(col, val, last, empty);
        @(posedge clk);
        #1 nz_valid = 1'b0;
        nz_last = 1'b0;
        nz_empty = 1'b0;
    endtask

    task automatic hold(string nm, logic [31:0] e0, logic [31:0] e1,
                        logic [31:0] e2, logic [9:0] idx);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(rv[0]), 32'd1);
        chk({nm, "_d0"}, rd[0], e0);
        chk({nm, "_d1"}, rd[1], e1);
        chk({nm, "_d2"}, rd[2], e2);
        chk({nm, "_idx"}, 32'(ri[0]), 32'(idx));
        chk({nm, "_busy"}, 32'(bsy[0]), 32'd0);
        @(posedge clk);
        #1 res_ready = 1'b1;
    endtask

    task automatic drain();
        int n;
        res_ready = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (sbq.size() != 0) begin
            ncmp++;
            nerr++;
            $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && rv[0] && res_ready) begin
            if (sbq.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL sb_empty: got unexpected row %h want none", rd[0]);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("sb_valid%0d", k), 32'(rv[k]), 32'd1);
                    chk($sformatf("sb_data%0d", k), rd[k], e.d[k]);
                    chk($sformatf("sb_idx%0d", k), 32'(ri[k]), 32'(e.i));
                end
            end
        end
    end

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{0, 3, 0, 0, 1};
        tbl[1]  = '{2, 4, 1, 0, 0};
        tbl[2]  = '{1, -8, 1, 0, 0};
        tbl[3]  = '{4, 1, 0, 0, 1};
        tbl[4]  = '{0, -1, 0, 0, 1};
        tbl[5]  = '{1, 50, 0, 1, 1};
        tbl[6]  = '{3, 7, 1, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 0};
        tbl[8]  = '{2, 127, 0, 0, 1};
        tbl[9]  = '{2, 127, 0, 0, 1};
        tbl[10] = '{2, 127, 0, 0, 1};
        tbl[11] = '{2, 127, 0, 0, 1};
        tbl[12] = '{2, 127, 1, 0, 0};
        tbl[13] = '{3, -128, 0, 0, 1};
        tbl[14] = '{3, -128, 0, 0, 1};
        tbl[15] = '{3, -128, 1, 0, 0};

        ncmp = 0;
        nerr = 0;
        rst_n = 1'b0;
        w_we = 1'b0;
        w_addr = '0;
        w_row = '0;
        nz_valid = 1'b0;
        nz_col = '0;
        nz_val = '0;
        nz_last = 1'b0;
        nz_empty = 1'b0;
        res_ready = 1'b1;
        model_reset();

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", 32'(rv[k]), 32'd0);
            chk("rst_data", rd[k], 32'd0);
            chk("rst_busy", 32'(bsy[k]) | 32'(er[k]) | 32'(ri[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load_identity();
        res_ready = 1'b0;
        send_beat(1, 5, 0, 0);
        chk("ident_busy_mid", 32'(bsy[0]), 32'd1);
        send_beat(3, -2, 1, 0);
        hold("ident", 32'hFE000500, 32'hFE000500, 32'hFF000100, 10'd0);
        drain();

        res_ready = 1'b0;
        send_beat(1, 9, 1, 0);
        fork
            begin
                send_beat(0, 2, 0, 0);
                send_beat(3, 3, 1, 0);
            end
            begin
                @(negedge clk);
                chk("bp_ready_low", 32'(rdy[0]), 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stable", rd[0], 32'h00000900);
                    chk("bp_idx", 32'(ri[0]), 32'd1);
                end
                @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        drain();

        for (int v = 0; v < 16; v++) begin
            send_beat(tbl[v].col, tbl[v].val, tbl[v].last, tbl[v].empty);
            chk($sformatf("tbl_busy%0d", v), 32'(bsy[0]), 32'(tbl[v].exp_busy));
        end
        drain();

        res_ready = 1'b0;
        send_beat(0, -7, 1, 0);
        hold("neg7", 32'h000000F9, 32'h000000F9, 32'h000000FE, 10'd9);
        drain();

        for (int i = 0; i < HN; i++) load_w(i, 32'h64646464);
        res_ready = 1'b0;
        for (int c = 0; c < 4; c++) send_beat(c, 100, c == 3, 0);
        hold("sat", 32'h7F7F7F7F, 32'h40404040, 32'h7F7F7F7F, 10'd10);
        drain();

        send_beat(5, 50, 0, 0);
        for (int k = 0; k < 3; k++) chk("err_set", 32'(er[k]), 32'd1);
        send_beat(0, 1, 1, 0);
        send_beat(1, 2, 1, 0);
        drain();
        chk("err_sticky", 32'(er[0]), 32'd1);

        send_beat(1, 3, 0, 0);
        chk("rst_mid_busy", 32'(bsy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rstm_valid", 32'(rv[k]), 32'd0);
            chk("rstm_err", 32'(er[k]) | 32'(bsy[k]), 32'd0);
            chk("rstm_data", rd[k] | 32'(ri[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_identity();
        res_ready = 1'b0;
        send_beat(2, 6, 1, 0);
        hold("post_rst", 32'h00060000, 32'h00060000, 32'h00010000, 10'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
